// File: rtl/pyrxsco_pkg.sv
// Shared definitions for the rx SCO/eSCO payload packer: FSM states,
// header word layout and small word-building helpers.
package pyrxsco_pkg;

    localparam int unsigned LEN_W         = 10;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned MAX_BYTES_DEF = 1020;

    // Header word layout (written at buffer address 0)
    localparam int unsigned HDR_CRC     = 31;
    localparam int unsigned HDR_TRUNC   = 30;
    localparam int unsigned HDR_OVF     = 29;
    localparam int unsigned HDR_LEN_MSB = 9;
    localparam int unsigned HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RX    = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HDR   = 2'd3
    } state_e;

    // Keep only the lowest nbytes whole bytes of a word
    function automatic logic [WORD_W-1:0] byte_mask(input logic [1:0] nbytes);
        logic [WORD_W-1:0] m;
        case (nbytes)
            2'd0:    m = 32'h0000_0000;
            2'd1:    m = 32'h0000_00FF;
            2'd2:    m = 32'h0000_FFFF;
            default: m = 32'h00FF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [WORD_W-1:0] hdr_word(input logic crc,
                                                   input logic trunc,
                                                   input logic ovf,
                                                   input logic [LEN_W-1:0] cnt);
        logic [WORD_W-1:0] w;
        w                          = '0;
        w[HDR_CRC]                 = crc;
        w[HDR_TRUNC]               = trunc;
        w[HDR_OVF]                 = ovf;
        w[HDR_LEN_MSB:HDR_LEN_LSB] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/pyrxscopack_shreg.sv
// LSB-first 32-bit payload shift register with bit, byte and word counters.
// word_rdy_o flags the bit that completes a word; word_o is that full word.
module pyrxscopack_shreg
    import pyrxsco_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] word_o,
    output logic [WORD_W-1:0] part_o,
    output logic              word_rdy_o,
    output logic [4:0]        bit_idx_o,
    output logic [LEN_W-1:0]  byte_cnt_o,
    output logic [ADDR_W-1:0] word_idx_o
);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [4:0]        bit_idx_q, bit_idx_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;

    // Next-state: clear on packet start, otherwise place one bit per accepted strobe
    always_comb begin
        sreg_d     = sreg_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        if (clr_i) begin
            sreg_d     = '0;
            bit_idx_d  = '0;
            byte_cnt_d = '0;
            word_idx_d = '0;
        end else if (shift_i) begin
            sreg_d[bit_idx_q] = bit_i;
            bit_idx_d         = bit_idx_q + 5'd1;
            if (bit_idx_q[2:0] == 3'd7)
                byte_cnt_d = byte_cnt_q + 1'b1;
            // Word leaves through word_o this cycle; start the next one from zero
            // so a later partial flush only needs masking of the partial byte.
            if (bit_idx_q == 5'd31) begin
                sreg_d     = '0;
                word_idx_d = word_idx_q + 1'b1;
            end
        end
    end

    // Counter and shift state registers
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            sreg_q     <= '0;
            bit_idx_q  <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
        end else begin
            sreg_q     <= sreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign word_o     = {bit_i, sreg_q[30:0]};
    assign word_rdy_o = shift_i & ~clr_i & (bit_idx_q == 5'd31);
    // Partial byte bits are dropped: keep only whole bytes of the current word
    assign part_o     = sreg_q & byte_mask(bit_idx_q[4:3]);
    assign bit_idx_o  = bit_idx_q;
    assign byte_cnt_o = byte_cnt_q;
    assign word_idx_o = word_idx_q;

endmodule

// File: rtl/pyrxscopack.sv
// Rx SCO/eSCO payload packer: packs decoded payload bits into 32-bit words,
// writes them from address 1 of the ping-pong buffer and closes each packet
// with a byte-count/status header at address 0.
module pyrxscopack
    import pyrxsco_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BYTES = 1020
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              tsco_p,
    input  logic              pkt_start_p,
    input  logic [9:0]        pyld_len,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              pkt_end_p,
    input  logic              crc_ok,
    output logic [ADDR_W-1:0] lnctrl_addr,
    output logic [DATA_W-1:0] lnctrl_din,
    output logic              lnctrl_we,
    output logic              lnctrl_cs,
    output logic [9:0]        byte_cnt,
    output logic              wr_done_p,
    output logic              ovf_err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_start;
    logic              ovf_q, crc_q, trunc_q, end_seen_q;
    logic              we_q, we_d, hdr_q, hdr_d, done_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              abort, shift, len_hit, end_now;

    logic [WORD_W-1:0] sh_word, sh_part;
    logic              sh_word_rdy;
    logic [4:0]        sh_bit_idx;
    logic [LEN_W-1:0]  sh_byte_cnt;
    logic [ADDR_W-1:0] sh_word_idx;

    assign len_start = (pyld_len > MAX_LEN) ? MAX_LEN : pyld_len;
    // A new start or an SCO boundary kills any write of the current packet
    assign abort     = pkt_start_p | tsco_p;
    assign len_hit   = (sh_byte_cnt == len_q);
    assign shift     = (state_q == ST_RX) & bit_valid & ~abort & ~pkt_end_p & ~len_hit;
    assign end_now   = end_seen_q | pkt_end_p;

    pyrxscopack_shreg #(.ADDR_W(ADDR_W)) u_shreg (
        .clk_6M     (clk_6M),
        .rstz       (rstz),
        .clr_i      (pkt_start_p),
        .shift_i    (shift),
        .bit_i      (bit_in),
        .word_o     (sh_word),
        .part_o     (sh_part),
        .word_rdy_o (sh_word_rdy),
        .bit_idx_o  (sh_bit_idx),
        .byte_cnt_o (sh_byte_cnt),
        .word_idx_o (sh_word_idx)
    );

    // FSM state register
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; a start pulse always wins over abort and completion
    always_comb begin
        state_d = state_q;
        if (pkt_start_p) begin
            state_d = (len_start == '0) ? ST_FLUSH : ST_RX;
        end else begin
            case (state_q)
                ST_RX:    if (tsco_p)                    state_d = ST_IDLE;
                          else if (pkt_end_p || len_hit) state_d = ST_FLUSH;
                ST_FLUSH: state_d = tsco_p ? ST_IDLE : ST_HDR;
                ST_HDR:   if (tsco_p || end_now)         state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: at most one buffer write request per clock
    always_comb begin
        we_d   = 1'b0;
        hdr_d  = 1'b0;
        addr_d = '0;
        din_d  = '0;
        if (!abort) begin
            case (state_q)
                ST_RX: if (sh_word_rdy) begin
                    we_d   = 1'b1;
                    addr_d = sh_word_idx + 1'b1;
                    din_d  = sh_word;
                end
                ST_FLUSH: if (sh_bit_idx != '0) begin
                    we_d   = 1'b1;
                    addr_d = sh_word_idx + 1'b1;
                    din_d  = sh_part;
                end
                ST_HDR: if (end_now) begin
                    we_d   = 1'b1;
                    hdr_d  = 1'b1;
                    din_d  = hdr_word(end_seen_q ? crc_q : crc_ok,
                                      end_seen_q ? trunc_q : 1'b0,
                                      ovf_q, sh_byte_cnt);
                end
                default: ;
            endcase
        end
    end

    // Packet context: latched length/overflow on start, CRC and truncation on end
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            len_q      <= '0;
            ovf_q      <= 1'b0;
            crc_q      <= 1'b0;
            trunc_q    <= 1'b0;
            end_seen_q <= 1'b0;
        end else if (pkt_start_p) begin
            len_q      <= len_start;
            ovf_q      <= (pyld_len > MAX_LEN);
            crc_q      <= 1'b0;
            trunc_q    <= 1'b0;
            end_seen_q <= 1'b0;
        end else if (pkt_end_p && !tsco_p && !end_seen_q && state_q != ST_IDLE) begin
            crc_q      <= crc_ok;
            trunc_q    <= (state_q == ST_RX) && (sh_byte_cnt < len_q);
            end_seen_q <= 1'b1;
        end
    end

    // Registered buffer port; wr_done_p follows the header write by one clock
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            we_q   <= 1'b0;
            hdr_q  <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            we_q   <= we_d;
            hdr_q  <= hdr_d;
            done_q <= hdr_q;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign lnctrl_addr = addr_q;
    assign lnctrl_din  = din_q;
    assign lnctrl_we   = we_q;
    assign lnctrl_cs   = we_q;
    assign byte_cnt    = sh_byte_cnt;
    assign wr_done_p   = done_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_pyrxscopack.sv
// Bench for pyrxscopack: byte-level reference model of expected buffer writes,
// directed vectors plus randomized packets.
module tb_pyrxscopack;

    logic       clk_6M = 1'b0;
    logic       rstz = 1'b0;
    logic       tsco_p = 1'b0, pkt_start_p = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
    logic       pkt_end_p = 1'b0, crc_ok = 1'b0;
    logic [9:0] pyld_len = '0;
    logic [7:0]  lnctrl_addr;
    logic [31:0] lnctrl_din;
    logic        lnctrl_we, lnctrl_cs, wr_done_p, ovf_err;
    logic [9:0]  byte_cnt;

    pyrxscopack dut (
        .clk_6M(clk_6M), .rstz(rstz), .tsco_p(tsco_p), .pkt_start_p(pkt_start_p),
        .pyld_len(pyld_len), .bit_valid(bit_valid), .bit_in(bit_in),
        .pkt_end_p(pkt_end_p), .crc_ok(crc_ok), .lnctrl_addr(lnctrl_addr),
        .lnctrl_din(lnctrl_din), .lnctrl_we(lnctrl_we), .lnctrl_cs(lnctrl_cs),
        .byte_cnt(byte_cnt), .wr_done_p(wr_done_p), .ovf_err(ovf_err)
    );

    always #5 clk_6M = ~clk_6M;

    int          checks = 0, failures = 0;
    int          done_cnt = 0, cs_bad = 0, exp_bc = 0;
    logic [7:0]  pl [0:1023];
    logic [39:0] got_q[$], exp_q[$];

    // Capture every buffer write as {addr, data}
    always @(negedge clk_6M) begin
        if (lnctrl_we === 1'b1) got_q.push_back({lnctrl_addr, lnctrl_din});
        if (lnctrl_cs !== lnctrl_we) cs_bad++;
        if (wr_done_p === 1'b1) done_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_6M); #1;
    endtask

    task automatic clear_mon();
        got_q.delete(); done_cnt = 0; cs_bad = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) pl[i] = 8'($urandom);
    endtask

    task automatic start_pkt(input int plen);
        pyld_len = 10'(plen); pkt_start_p = 1'b1; tick(); pkt_start_p = 1'b0;
    endtask

    // One bit every 6 clocks, LSB of each byte first
    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bit_in = pl[i/8][i%8]; bit_valid = 1'b1; tick();
            bit_valid = 1'b0; bit_in = 1'b0; repeat (5) tick();
        end
    endtask

    task automatic end_pkt(input bit crc);
        repeat (2) tick();
        crc_ok = crc; pkt_end_p = 1'b1; tick(); pkt_end_p = 1'b0; crc_ok = 1'b0;
        repeat (6) tick();
    endtask

    // Expected writes for a packet that receives nbits bits and then ends
    task automatic model_pkt(input int plen, input int nbits, input bit crc);
        int eff, acc, ab, full;
        bit ovf;
        logic [31:0] w;
        exp_q.delete();
        ovf  = (plen > 1020);
        eff  = ovf ? 1020 : plen;
        acc  = (nbits < eff*8) ? nbits : eff*8;
        ab   = acc / 8;
        full = acc / 32;
        for (int wi = 0; wi < full; wi++) begin
            w = {pl[4*wi+3], pl[4*wi+2], pl[4*wi+1], pl[4*wi]};
            exp_q.push_back({8'(wi+1), w});
        end
        if (acc % 32 != 0) begin
            w = '0;
            for (int k = 0; k < ab - 4*full; k++) w[8*k +: 8] = pl[4*full+k];
            exp_q.push_back({8'(full+1), w});
        end
        w = '0; w[31] = crc; w[30] = (ab < eff); w[29] = ovf; w[9:0] = 10'(ab);
        exp_q.push_back({8'h00, w});
        exp_bc = ab;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({lnctrl_we, lnctrl_cs, wr_done_p, ovf_err} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {lnctrl_we, lnctrl_cs, wr_done_p, ovf_err}); end
        checks++; if ({lnctrl_addr, lnctrl_din} !== 40'h0) begin
            failures++; $display("FAIL reset_bus got=%h exp=0", {lnctrl_addr, lnctrl_din}); end
        checks++; if (byte_cnt !== 10'd0) begin
            failures++; $display("FAIL reset_byte_cnt got=%0d exp=0", byte_cnt); end
        @(negedge clk_6M); rstz = 1'b1; tick();
    endtask

    task automatic test_hv3();
        for (int i = 0; i < 30; i++) pl[i] = 8'(i);
        clear_mon(); model_pkt(30, 240, 1'b1);
        start_pkt(30); send_bits(240); end_pkt(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL hv3_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL hv3_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() < 9 || got_q[0] !== 40'h01_03020100 || got_q[7] !== 40'h08_00001D1C) begin
            failures++; $display("FAIL hv3_words got=%0d entries exp=9 with 01:03020100 and 08:00001d1c", got_q.size()); end
        checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 40'h00_8000001E) begin
            failures++; $display("FAIL hv3_hdr got_n=%0d exp=00_8000001e", got_q.size()); end
        checks++; if (done_cnt != 1) begin
            failures++; $display("FAIL hv3_done got=%0d exp=1", done_cnt); end
        checks++; if (byte_cnt !== 10'd30 || cs_bad != 0) begin
            failures++; $display("FAIL hv3_cnt_cs got=%0d/%0d exp=30/0", byte_cnt, cs_bad); end
    endtask

    task automatic test_hv1();
        fill_random(); clear_mon(); model_pkt(10, 44, 1'b0);
        start_pkt(10); send_bits(44); end_pkt(1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL hv1_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL hv1_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() != 3 || got_q[2] !== 40'h00_40000005 || got_q[1][39:8] !== 32'h02_000000) begin
            failures++; $display("FAIL hv1_tail got_n=%0d exp=3 with 02:000000xx and 00:40000005", got_q.size()); end
        checks++; if (done_cnt != 1) begin
            failures++; $display("FAIL hv1_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_ovf();
        fill_random(); clear_mon(); model_pkt(1023, 8160, 1'b1);
        start_pkt(1023);
        checks++; if (ovf_err !== 1'b1) begin
            failures++; $display("FAIL ovf_flag got=%b exp=1", ovf_err); end
        send_bits(8160 + 16); end_pkt(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL ovf_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() < 2 || got_q[got_q.size()-2][39:32] !== 8'hFF || got_q[got_q.size()-1] !== 40'h00_A00003FC) begin
            failures++; $display("FAIL ovf_tail got_n=%0d exp last addr ff and hdr a00003fc", got_q.size()); end
        checks++; if (byte_cnt !== 10'd1020 || done_cnt != 1) begin
            failures++; $display("FAIL ovf_cnt got=%0d/%0d exp=1020/1", byte_cnt, done_cnt); end
    endtask

    task automatic test_abort();
        fill_random(); clear_mon(); model_pkt(30, 96, 1'b1);
        void'(exp_q.pop_back());
        start_pkt(30); send_bits(100);
        tsco_p = 1'b1; tick(); tsco_p = 1'b0;
        send_bits(40); end_pkt(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL abort_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL abort_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 0) begin
            failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        checks++; if (byte_cnt !== 10'd12) begin
            failures++; $display("FAIL abort_byte_cnt got=%0d exp=12", byte_cnt); end
    endtask

    task automatic test_extra_bits();
        fill_random(); clear_mon(); model_pkt(10, 96, 1'b1);
        start_pkt(10); send_bits(96); end_pkt(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL extra_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL extra_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (byte_cnt !== 10'd10 || done_cnt != 1) begin
            failures++; $display("FAIL extra_cnt got=%0d/%0d exp=10/1", byte_cnt, done_cnt); end
    endtask

    task automatic test_len0();
        fill_random(); clear_mon(); model_pkt(0, 8, 1'b1);
        start_pkt(0); send_bits(8); end_pkt(1'b1);
        checks++; if (got_q.size() != 1 || got_q[0] !== 40'h00_80000000) begin
            failures++; $display("FAIL len0_hdr got_n=%0d exp single 00:80000000", got_q.size()); end
        checks++; if (byte_cnt !== 10'd0 || done_cnt != 1) begin
            failures++; $display("FAIL len0_cnt got=%0d/%0d exp=0/1", byte_cnt, done_cnt); end
    endtask

    // Restart mid-packet with tsco_p on the same clock: the new packet wins
    task automatic test_restart();
        fill_random(); clear_mon();
        start_pkt(20); send_bits(40);
        clear_mon(); model_pkt(8, 64, 1'b0);
        pyld_len = 10'd8; pkt_start_p = 1'b1; tsco_p = 1'b1; tick();
        pkt_start_p = 1'b0; tsco_p = 1'b0;
        send_bits(64); end_pkt(1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL restart_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL restart_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin
            failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_rst_mid();
        fill_random(); clear_mon();
        start_pkt(1023); send_bits(50);
        checks++; if (byte_cnt !== 10'd6 || ovf_err !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre got=%0d/%b exp=6/1", byte_cnt, ovf_err); end
        @(posedge clk_6M); #2; rstz = 1'b0; #1;
        checks++; if ({lnctrl_we, lnctrl_cs, wr_done_p, ovf_err, byte_cnt, lnctrl_addr, lnctrl_din} !== 54'h0) begin
            failures++; $display("FAIL rstmid_zero got=%b%b%b%b cnt=%0d bus=%h exp all 0",
                lnctrl_we, lnctrl_cs, wr_done_p, ovf_err, byte_cnt, {lnctrl_addr, lnctrl_din}); end
        @(negedge clk_6M); rstz = 1'b1; tick();
        fill_random(); clear_mon(); model_pkt(8, 64, 1'b1);
        start_pkt(8); send_bits(64); end_pkt(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rstmid_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rstmid_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            int plen, nbits;
            bit crc;
            fill_random();
            plen  = $urandom_range(0, 40);
            nbits = ($urandom_range(0, 1) == 1) ? $urandom_range(0, plen*8)
                                                : plen*8 + $urandom_range(0, 20);
            crc   = 1'($urandom);
            clear_mon(); model_pkt(plen, nbits, crc);
            start_pkt(plen); send_bits(nbits); end_pkt(crc);
            checks++; if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_nwr len=%0d bits=%0d got=%0d exp=%0d", p, plen, nbits, got_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++; if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand%0d_wr[%0d] got=%h exp=%h", p, i, got_q[i], exp_q[i]); end
            end
            checks++; if (byte_cnt !== 10'(exp_bc) || done_cnt != 1 || cs_bad != 0) begin
                failures++; $display("FAIL rand%0d_status got=%0d/%0d/%0d exp=%0d/1/0", p, byte_cnt, done_cnt, cs_bad, exp_bc); end
        end
    endtask

    initial begin
        test_reset();
        test_hv3();
        test_hv1();
        test_len0();
        test_extra_bits();
        test_abort();
        test_restart();
        test_rst_mid();
        test_random();
        test_ovf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
